// File: rtl/int_sub_pipe_32_pkg.sv
// Shared types and widths for the two-stage 32-bit subtractor (package fsub_pkg).
package fsub_pkg;
    localparam int DIFF_W    = 32;
    localparam int HALF_W    = 16;
    localparam int TAG_MAX_W = 16;

    // Tag field is sized for the widest station tag; narrower tags are zero-extended.
    typedef struct packed {
        logic [HALF_W-1:0]    a_hi;
        logic [HALF_W-1:0]    nb_hi;
        logic [HALF_W-1:0]    lo_diff;
        logic                 c16;
        logic                 a31;
        logic                 b31;
        logic [TAG_MAX_W-1:0] tag;
    } s1_t;
endpackage

// File: rtl/int_sub_pipe_32_if.sv
// Request/result handshake bundle between reservation stations and the subtractor.
interface int_sub_pipe_32_if
    import fsub_pkg::*;
#(
    parameter int TAG_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DIFF_W-1:0] in_a;
    logic [DIFF_W-1:0] in_b;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DIFF_W-1:0] out_diff;
    logic              out_borrow;
    logic [TAG_W-1:0]  out_tag;
    logic              out_zero;
    logic              out_neg;
    logic              out_ovf;

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_diff, out_borrow, out_tag,
               out_zero, out_neg, out_ovf
    );

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_diff, out_borrow, out_tag,
               out_zero, out_neg, out_ovf
    );
endinterface

// File: rtl/int_sub_pipe_32_kgp_adder_16.sv
// 16-bit Kogge-Stone (KGP recursive doubling) adder; carry-in is folded into bit 0's generate.
module kgp_adder_16
    import fsub_pkg::*;
(
    input  logic [HALF_W-1:0] i_a,
    input  logic [HALF_W-1:0] i_b,
    input  logic              i_cin,
    output logic [HALF_W-1:0] o_sum,
    output logic              o_cout
);
    logic [HALF_W-1:0] w_p0, w_g0, w_g1, w_g2, w_g3, w_g4;
    logic [HALF_W-1:2] w_p1;
    logic [HALF_W-1:4] w_p2;
    logic [HALF_W-1:8] w_p3;

    assign w_p0 = i_a ^ i_b;
    assign w_g0 = {i_a[HALF_W-1:1] & i_b[HALF_W-1:1], (i_a[0] & i_b[0]) | (w_p0[0] & i_cin)};

    for (genvar i = 0; i < HALF_W; i++) begin : g_l1
        if (i >= 1) begin : g_op
            assign w_g1[i] = w_g0[i] | (w_p0[i] & w_g0[i-1]);
        end else begin : g_pass
            assign w_g1[i] = w_g0[i];
        end
        if (i >= 2) begin : g_pp
            assign w_p1[i] = w_p0[i] & w_p0[i-1];
        end
    end

    for (genvar i = 0; i < HALF_W; i++) begin : g_l2
        if (i >= 2) begin : g_op
            assign w_g2[i] = w_g1[i] | (w_p1[i] & w_g1[i-2]);
        end else begin : g_pass
            assign w_g2[i] = w_g1[i];
        end
        if (i >= 4) begin : g_pp
            assign w_p2[i] = w_p1[i] & w_p1[i-2];
        end
    end

    for (genvar i = 0; i < HALF_W; i++) begin : g_l3
        if (i >= 4) begin : g_op
            assign w_g3[i] = w_g2[i] | (w_p2[i] & w_g2[i-4]);
        end else begin : g_pass
            assign w_g3[i] = w_g2[i];
        end
        if (i >= 8) begin : g_pp
            assign w_p3[i] = w_p2[i] & w_p2[i-4];
        end
    end

    for (genvar i = 0; i < HALF_W; i++) begin : g_l4
        if (i >= 8) begin : g_op
            assign w_g4[i] = w_g3[i] | (w_p3[i] & w_g3[i-8]);
        end else begin : g_pass
            assign w_g4[i] = w_g3[i];
        end
    end

    assign o_sum  = w_p0 ^ {w_g4[HALF_W-2:0], i_cin};
    assign o_cout = w_g4[HALF_W-1];
endmodule

// File: rtl/int_sub_pipe_32.sv
// Two-stage A-B subtractor (A + ~B + 1), low half in S1, high half in S2, tag passthrough.
// Define FSUB_FLAGS_EN to register zero/negative/signed-overflow flags; otherwise flags read 0.
module int_sub_pipe_32
    import fsub_pkg::*;
#(
    parameter int TAG_W = 5
)(
    input  logic              clk,
    input  logic              rst_n,
    int_sub_pipe_32_if.slave  bus
);
    logic [DIFF_W-1:0] w_nb;
    logic [HALF_W-1:0] w_lo_sum, w_hi_sum;
    logic              w_c16, w_c32, w_accept, w_s2_adv;
    s1_t               w_s1_nxt, r_s1;
    logic              r_s1_vld, r_s2_vld;
    logic [DIFF_W-1:0] r_diff;
    logic              r_borrow;
    logic [TAG_W-1:0]  r_tag;
    logic              w_unused_tag;

    assign w_nb = ~bus.in_b;

    kgp_adder_16 u_lo (
        .i_a(bus.in_a[HALF_W-1:0]), .i_b(w_nb[HALF_W-1:0]), .i_cin(1'b1),
        .o_sum(w_lo_sum), .o_cout(w_c16)
    );

    kgp_adder_16 u_hi (
        .i_a(r_s1.a_hi), .i_b(r_s1.nb_hi), .i_cin(r_s1.c16),
        .o_sum(w_hi_sum), .o_cout(w_c32)
    );

    assign w_s2_adv     = r_s1_vld && (!r_s2_vld || bus.out_ready);
    assign bus.in_ready = !r_s1_vld || w_s2_adv;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_unused_tag = ^r_s1.tag;

    always_comb begin
        w_s1_nxt         = '0;
        w_s1_nxt.a_hi    = bus.in_a[DIFF_W-1:HALF_W];
        w_s1_nxt.nb_hi   = w_nb[DIFF_W-1:HALF_W];
        w_s1_nxt.lo_diff = w_lo_sum;
        w_s1_nxt.c16     = w_c16;
        w_s1_nxt.tag     = TAG_MAX_W'(bus.in_tag);
`ifdef FSUB_FLAGS_EN
        w_s1_nxt.a31     = bus.in_a[DIFF_W-1];
        w_s1_nxt.b31     = bus.in_b[DIFF_W-1];
`endif
    end

    // Stage 1: low-half difference and inter-half carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1     <= '0;
        end else begin
            if (w_accept) begin
                r_s1     <= w_s1_nxt;
                r_s1_vld <= 1'b1;
            end else if (w_s2_adv) begin
                r_s1_vld <= 1'b0;
            end
        end
    end

    // Stage 2: high-half difference, borrow and result hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_tag    <= '0;
        end else if (w_s2_adv) begin
            r_s2_vld <= 1'b1;
            r_diff   <= {w_hi_sum, r_s1.lo_diff};
            r_borrow <= ~w_c32;
            r_tag    <= r_s1.tag[TAG_W-1:0];
        end else if (bus.out_ready) begin
            r_s2_vld <= 1'b0;
        end
    end

`ifdef FSUB_FLAGS_EN
    logic r_zero, r_neg, r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_s2_adv) begin
            r_zero <= ({w_hi_sum, r_s1.lo_diff} == '0);
            r_neg  <= w_hi_sum[HALF_W-1];
            r_ovf  <= (r_s1.a31 != r_s1.b31) && (w_hi_sum[HALF_W-1] != r_s1.a31);
        end
    end

    assign bus.out_zero = r_zero;
    assign bus.out_neg  = r_neg;
    assign bus.out_ovf  = r_ovf;
`else
    logic w_unused_flag;

    assign w_unused_flag = r_s1.a31 ^ r_s1.b31;
    assign bus.out_zero  = 1'b0;
    assign bus.out_neg   = 1'b0;
    assign bus.out_ovf   = 1'b0;
`endif

    assign bus.out_valid  = r_s2_vld;
    assign bus.out_diff   = r_diff;
    assign bus.out_borrow = r_borrow;
    assign bus.out_tag    = r_tag;
endmodule

// File: doc/int_sub_pipe_32.md
# int_sub_pipe_32

Two-stage pipelined 32-bit integer subtractor computing A − B with a valid/ready handshake and reservation-station tag passthrough. It is the subtract-direction counterpart of the FADD 32-bit prefix adder. Subtraction is A + ~B + 1, split into a low-half and a high-half 16-bit prefix (KGP) addition, one per stage, with the inter-half carry registered between stages. It sits between the reservation stations and the common data bus arbiter.

## Interface
Parameters:
- TAG_W, 5, width of the reservation-station tag carried alongside each operation.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request this cycle.
- in_a  in  32  minuend.
- in_b  in  32  subtrahend.
- in_tag  in  TAG_W  issuing station tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result this cycle.
- out_diff  out  32  A − B, modulo 2^32.
- out_borrow  out  1  1 when A < B (unsigned), i.e. inverted final carry.
- out_tag  out  TAG_W  tag of the result.
- out_zero, out_neg, out_ovf  out  1 each  flags; see Configuration.

## Operation
- Stage 1 (S1) on accept: registers diff[15:0] = a[15:0] + ~b[15:0] + 1, carry c16, a[31:16], ~b[31:16], and the tag. Sets s1_valid.
- Stage 2 (S2) on advance: registers diff[31:16] = a_hi + nb_hi + c16, and passes diff[15:0] through. Registers borrow = ~c32, tag, and flags. Sets s2_valid.
- A request is accepted when in_valid && in_ready.
- s2_adv = s1_valid && (!s2_valid || out_ready).
- in_ready = !s1_valid || s2_adv. This is combinational from state and out_ready.
- Empty S2 with no advance: s2_valid clears when out_ready is high.
- Simultaneous accept and S1→S2 advance: S1 reloads in the same cycle with no bubble.
- out_* signals are driven directly from S2 registers. While out_valid && !out_ready, they hold stable.
- Results leave in strict acceptance order. No reordering, drops, or duplication.
- Reset, asynchronous, including mid-operation: s1_valid = s2_valid = 0, and all data, tag, and flag registers = 0. The pipeline is flushed and in-flight operations are discarded.
- Reset values: out_valid 0, out_diff 0, out_borrow 0, out_tag 0, flags 0. in_ready reads 1 while pipeline is empty.

## Timing
- Latency: accept at edge N → out_valid high after edge N+1, so the result is visible in cycle N+2 (2 cycles).
- Throughput: 1 operation per cycle with out_ready held high.
- With both stages full and out_ready low, in_ready = 0. When out_ready rises, in_ready rises in the same cycle.
- The critical path per stage is one 16-bit prefix adder (4 KGP levels) plus a register.

## Configuration
- FSUB_FLAGS_EN defined:
  - out_zero = (diff == 0).
  - out_neg = diff[31].
  - out_ovf = (a[31] != b[31]) && (diff[31] != a[31]) (signed overflow). S1 carries a[31] and b[31] forward for this.
  - All flags are registered in S2 alongside diff.
- FSUB_FLAGS_EN undefined: flag ports remain, tied to 0. No flag registers are synthesised.

## Structure
- Shared package fsub_pkg: DIFF_W = 32, HALF_W = 16, and a packed struct s1_t {a_hi, nb_hi, lo_diff, c16, a31, b31, tag}.
- One sub-module: kgp_adder_16. This is a 16-bit recursive-doubling KGP adder with carry-in and carry-out, instantiated twice: S1 low half and S2 high half.
- Pipeline control lives in the top module.

## Test plan
- A=0x0000_0005, B=0x0000_0003, tag 7 → two cycles later: diff 0x0000_0002, borrow 0, tag 7, zero 0, neg 0.
- A=0x0000_0003, B=0x0000_0005 → diff 0xFFFF_FFFE, borrow 1, neg 1, ovf 0.
- Cross-half borrow: A=0x0001_0000, B=0x0000_0001 → diff 0x0000_FFFF, borrow 0. A=B=0x1234_5678 → diff 0, zero 1.
- Signed overflow: A=0x8000_0000, B=0x0000_0001 → diff 0x7FFF_FFFF, ovf 1, neg 0. With FSUB_FLAGS_EN undefined, all flags are 0.
- Backpressure: stream tags 1..6 back-to-back with out_ready low for 3 cycles mid-stream → in_ready drops once both stages are full. All 6 results emerge in order with correct diffs, and outputs are stable while stalled.
- Reset mid-flight: assert rst_n low with both stages valid → out_valid goes to 0 immediately (asynchronous), no stale result appears after release, and in_ready is 1 in the first cycle after release.
